// File: rtl/mips_bus_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mips_bus_ram : word-addressed RAM slave on the MIPS CPU bus (waitrequest).
// Option macro BUS_RAM_RANDOM_STALL_EN adds LFSR-driven extra wait states.
// Revision : 1.0
// ============================================================================
module mips_bus_ram #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 1024,
  parameter              INIT_FILE   = "ram.txt",
  parameter int          WAIT_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        err
);

  localparam int c_idx_w = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [4:0]         r_cnt;
  logic [4:0]         w_cnt_nx;
  logic [4:0]         w_load;
  logic [1:0]         w_stall;
  logic [31:0]        r_readdata;
  logic               r_err;
  logic               w_latch;
  logic               w_commit;
  logic               w_req;
  logic [29:0]        w_word;
  logic [c_idx_w-1:0] w_idx;
  logic               w_in_range;
  logic               w_halt;
  logic               w_bad;
  logic [31:0]        w_rd_word;
  logic               w_unused_addr_lsb;

  logic [31:0] r_mem [DEPTH_WORDS];

  // Byte offset bits carry no meaning on a word-addressed slave.
  assign w_unused_addr_lsb = ^address[1:0];

  assign w_req      = read | write;
  assign w_word     = address[31:2] - BASE_ADDR[31:2];
  assign w_idx      = w_word[c_idx_w-1:0];
  assign w_in_range = (address >= BASE_ADDR) && (w_word < 30'(DEPTH_WORDS));
  assign w_halt     = (address[31:2] == 30'd0);
  assign w_bad      = (!w_in_range && !w_halt) || (read && write);
  assign w_rd_word  = w_in_range ? r_mem[w_idx] : 32'd0;
  assign w_load     = 5'(WAIT_CYCLES) + {3'd0, w_stall};
  assign w_commit   = (r_state == ST_ACK) && write && w_in_range;

`ifdef BUS_RAM_RANDOM_STALL_EN
  logic [15:0] r_lfsr;

  // Fibonacci taps 16,14,13,11; steps once per accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else if ((r_state == ST_IDLE) && w_req) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_stall = r_lfsr[1:0];
`else
  logic [15:0] w_unused_seed;
  assign w_unused_seed = LFSR_SEED;
  assign w_stall       = 2'd0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_latch    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_load != 5'd0) begin
            w_state_nx = ST_WAIT;
            w_cnt_nx   = w_load;
          end else begin
            w_state_nx = ST_ACK;
            w_latch    = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!w_req) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = 5'd0;
        end else if (r_cnt == 5'd1) begin
          w_state_nx = ST_ACK;
          w_cnt_nx   = 5'd0;
          w_latch    = 1'b1;
        end else begin
          w_cnt_nx   = r_cnt - 5'd1;
        end
      end
      ST_ACK:  w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 5'd0;
      r_readdata <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_latch && w_bad) r_err <= 1'b1;
      // A simultaneous read+write is a write, so readdata is left alone.
      if (w_latch && !write) begin
        for (int i = 0; i < 4; i++) begin
          if (byteenable[i]) r_readdata[8*i +: 8] <= w_rd_word[31-8*i -: 8];
        end
      end
    end
  end

  // Lanes are stored byte-reversed within the word to match the image layout.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) r_mem[w_idx][31-8*i -: 8] <= writedata[8*i +: 8];
      end
    end
  end

  assign readdata    = r_readdata;
  assign waitrequest = (r_state != ST_ACK);
  assign err         = r_err;

endmodule
`default_nettype wire
